// File: rtl/at_decoder.sv
// Hazard-unit instruction classifier for the MIPS Decode stage.
// Maps an instruction word to its read/write register numbers and a type code.
module at_decoder (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] Instr,
    output logic [4:0]  RS,
    output logic [4:0]  RT,
    output logic [4:0]  WR,
    output logic [3:0]  Instype
);

    localparam logic [3:0] T_NOP    = 4'd0;
    localparam logic [3:0] T_CAL_R  = 4'd1;
    localparam logic [3:0] T_CAL_I  = 4'd2;
    localparam logic [3:0] T_LOAD   = 4'd3;
    localparam logic [3:0] T_STORE  = 4'd4;
    localparam logic [3:0] T_BRANCH = 4'd5;
    localparam logic [3:0] T_JAL    = 4'd6;
    localparam logic [3:0] T_JR     = 4'd7;
    localparam logic [3:0] T_JALR   = 4'd8;
    localparam logic [3:0] T_J      = 4'd9;

    logic [5:0] w_op;
    logic [4:0] w_rs;
    logic [4:0] w_rt;
    logic [4:0] w_rd;
    logic [5:0] w_funct;
    logic       w_unused;

    assign w_op    = Instr[31:26];
    assign w_rs    = Instr[25:21];
    assign w_rt    = Instr[20:16];
    assign w_rd    = Instr[15:11];
    assign w_funct = Instr[5:0];

    // Clock, reset and shamt are not used by any decode path.
    assign w_unused = &{1'b0, Clk, Reset, Instr[10:6]};

    // Decode instruction fields into hazard-relevant registers and class.
    always_comb begin
        Instype = T_NOP;
        RS      = 5'd0;
        RT      = 5'd0;
        WR      = 5'd0;
        // An all-zero word is the canonical nop and must not decode as sll.
        if (Instr == 32'h0000_0000) begin
            Instype = T_NOP;
        end else begin
            case (w_op)
                6'h00: begin
                    case (w_funct)
                        6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                        6'h2A, 6'h2B, 6'h04, 6'h06, 6'h07: begin
                            Instype = T_CAL_R;
                            RS      = w_rs;
                            RT      = w_rt;
                            WR      = w_rd;
                        end
                        6'h00, 6'h02, 6'h03: begin
                            Instype = T_CAL_R;
                            RT      = w_rt;
                            WR      = w_rd;
                        end
                        6'h08: begin
                            Instype = T_JR;
                            RS      = w_rs;
                        end
                        6'h09: begin
                            Instype = T_JALR;
                            RS      = w_rs;
                            WR      = w_rd;
                        end
                        default: begin
                            Instype = T_NOP;
                        end
                    endcase
                end
                6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E: begin
                    Instype = T_CAL_I;
                    RS      = w_rs;
                    WR      = w_rt;
                end
                6'h0F: begin
                    Instype = T_CAL_I;
                    WR      = w_rt;
                end
                6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
                    Instype = T_LOAD;
                    RS      = w_rs;
                    WR      = w_rt;
                end
                6'h28, 6'h29, 6'h2B: begin
                    Instype = T_STORE;
                    RS      = w_rs;
                    RT      = w_rt;
                end
                6'h04, 6'h05: begin
                    Instype = T_BRANCH;
                    RS      = w_rs;
                    RT      = w_rt;
                end
                6'h01, 6'h06, 6'h07: begin
                    Instype = T_BRANCH;
                    RS      = w_rs;
                end
                6'h03: begin
                    Instype = T_JAL;
                    WR      = 5'd31;
                end
                6'h02: begin
                    Instype = T_J;
                end
                default: begin
                    Instype = T_NOP;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_at_decoder.sv
// Self-checking bench for at_decoder: directed vector table, random stimulus
// against a table-driven reference model, and a clock/reset independence check.
module tb_at_decoder;

    logic        Clk;
    logic        Reset;
    logic [31:0] Instr;
    logic [4:0]  RS;
    logic [4:0]  RT;
    logic [4:0]  WR;
    logic [3:0]  Instype;

    int n_checks;
    int n_errors;

    at_decoder dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .Instr   (Instr),
        .RS      (RS),
        .RT      (RT),
        .WR      (WR),
        .Instype (Instype)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [31:0] instr;
        logic [3:0]  t;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  wr;
    } vec_t;

    // Reference model tables: for each opcode / SPECIAL funct, the class and
    // which instruction field feeds each register output.
    // src selectors: 0 = none, 1 = rs field, 2 = rt field, 3 = rd field, 4 = const 31
    int op_type [64];
    int op_rs   [64];
    int op_rt   [64];
    int op_wr   [64];
    int sp_type [64];
    int sp_rs   [64];
    int sp_rt   [64];
    int sp_wr   [64];

    task automatic set_op(input int code, input int t, input int a, input int b, input int c);
        op_type[code] = t; op_rs[code] = a; op_rt[code] = b; op_wr[code] = c;
    endtask

    task automatic set_sp(input int code, input int t, input int a, input int b, input int c);
        sp_type[code] = t; sp_rs[code] = a; sp_rt[code] = b; sp_wr[code] = c;
    endtask

    task automatic build_model;
        int calr[13];
        int cali[7];
        int ld[5];
        int st[3];
        calr = '{'h21, 'h23, 'h20, 'h22, 'h24, 'h25, 'h26, 'h27, 'h2A, 'h2B, 'h04, 'h06, 'h07};
        cali = '{'h08, 'h09, 'h0A, 'h0B, 'h0C, 'h0D, 'h0E};
        ld   = '{'h20, 'h21, 'h23, 'h24, 'h25};
        st   = '{'h28, 'h29, 'h2B};
        for (int i = 0; i < 64; i++) begin
            set_op(i, 0, 0, 0, 0);
            set_sp(i, 0, 0, 0, 0);
        end
        foreach (calr[i]) set_sp(calr[i], 1, 1, 2, 3);
        set_sp('h00, 1, 0, 2, 3);
        set_sp('h02, 1, 0, 2, 3);
        set_sp('h03, 1, 0, 2, 3);
        set_sp('h08, 7, 1, 0, 0);
        set_sp('h09, 8, 1, 0, 3);
        foreach (cali[i]) set_op(cali[i], 2, 1, 0, 2);
        set_op('h0F, 2, 0, 0, 2);
        foreach (ld[i]) set_op(ld[i], 3, 1, 0, 2);
        foreach (st[i]) set_op(st[i], 4, 1, 2, 0);
        set_op('h04, 5, 1, 2, 0);
        set_op('h05, 5, 1, 2, 0);
        set_op('h06, 5, 1, 0, 0);
        set_op('h07, 5, 1, 0, 0);
        set_op('h01, 5, 1, 0, 0);
        set_op('h03, 6, 0, 0, 4);
        set_op('h02, 9, 0, 0, 0);
    endtask

    function automatic logic [4:0] pick(input int sel, input logic [31:0] ins);
        case (sel)
            1:       return ins[25:21];
            2:       return ins[20:16];
            3:       return ins[15:11];
            4:       return 5'd31;
            default: return 5'd0;
        endcase
    endfunction

    function automatic vec_t model(input logic [31:0] ins);
        vec_t v;
        int   op;
        int   fn;
        op = int'(ins[31:26]);
        fn = int'(ins[5:0]);
        v.instr = ins;
        if (ins == 32'h0000_0000) begin
            v.t = 4'd0; v.rs = 5'd0; v.rt = 5'd0; v.wr = 5'd0;
        end else if (op == 0) begin
            v.t  = 4'(sp_type[fn]);
            v.rs = pick(sp_rs[fn], ins);
            v.rt = pick(sp_rt[fn], ins);
            v.wr = pick(sp_wr[fn], ins);
        end else begin
            v.t  = 4'(op_type[op]);
            v.rs = pick(op_rs[op], ins);
            v.rt = pick(op_rt[op], ins);
            v.wr = pick(op_wr[op], ins);
        end
        return v;
    endfunction

    task automatic check(input string name, input vec_t exp);
        n_checks++;
        if ({Instype, RS, RT, WR} !== {exp.t, exp.rs, exp.rt, exp.wr}) begin
            n_errors++;
            $display("FAIL %s instr=%h got type=%0d rs=%0d rt=%0d wr=%0d expected type=%0d rs=%0d rt=%0d wr=%0d",
                     name, exp.instr, Instype, RS, RT, WR, exp.t, exp.rs, exp.rt, exp.wr);
        end
    endtask

    vec_t vecs[14];
    int   ops[24];

    initial begin
        n_checks = 0;
        n_errors = 0;
        Reset    = 1'b1;
        Instr    = 32'h0000_0000;
        build_model();

        vecs[0]  = '{32'h00221821, 4'd1, 5'd1,  5'd2, 5'd3};
        vecs[1]  = '{32'h34850010, 4'd2, 5'd4,  5'd0, 5'd5};
        vecs[2]  = '{32'h8D280004, 4'd3, 5'd9,  5'd0, 5'd8};
        vecs[3]  = '{32'hAD280004, 4'd4, 5'd9,  5'd8, 5'd0};
        vecs[4]  = '{32'h10220003, 4'd5, 5'd1,  5'd2, 5'd0};
        vecs[5]  = '{32'h0C000010, 4'd6, 5'd0,  5'd0, 5'd31};
        vecs[6]  = '{32'h03E00008, 4'd7, 5'd31, 5'd0, 5'd0};
        vecs[7]  = '{32'h00A0F809, 4'd8, 5'd5,  5'd0, 5'd31};
        vecs[8]  = '{32'h00000000, 4'd0, 5'd0,  5'd0, 5'd0};
        vecs[9]  = '{32'hFC000000, 4'd0, 5'd0,  5'd0, 5'd0};
        vecs[10] = '{32'h00021080, 4'd1, 5'd0,  5'd2, 5'd2};  // sll $2,$2,2
        vecs[11] = '{32'h3C070001, 4'd2, 5'd0,  5'd0, 5'd7};  // lui $7,1
        vecs[12] = '{32'h0022180C, 4'd0, 5'd0,  5'd0, 5'd0};  // syscall funct
        vecs[13] = '{32'h08000004, 4'd9, 5'd0,  5'd0, 5'd0};  // j

        // Outputs must not depend on Reset being asserted.
        @(negedge Clk);
        Instr = 32'h00221821;
        #1;
        check("under_reset", vecs[0]);
        Reset = 1'b0;

        for (int i = 0; i < 14; i++) begin
            Instr = vecs[i].instr;
            #1;
            check("vector", vecs[i]);
        end

        ops = '{0, 0, 0, 0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 'h0A, 'h0B, 'h0C,
                'h0D, 'h0E, 'h0F, 'h20, 'h23, 'h25, 'h2B, 'h29};
        for (int i = 0; i < 400; i++) begin
            logic [31:0] r;
            r = $urandom;
            if (i % 3 != 2) r[31:26] = 6'(ops[$urandom_range(0, 23)]);
            if (i % 5 == 0) r[5:0] = 6'($urandom_range(0, 11));
            Instr = r;
            #1;
            check("random", model(r));
        end

        // Hold one instruction while clocking and pulsing Reset.
        Instr = 32'hAD280004;
        for (int c = 0; c < 6; c++) begin
            Reset = (c == 2 || c == 3) ? 1'b1 : 1'b0;
            @(posedge Clk);
            #1;
            check("hold_clk_reset", vecs[3]);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
